// File: rtl/microwave_pkg.sv
// microwave_pkg
// Shared constants for the microwave timer front end: FSM state encoding,
// BCD digit limits and a digit-validity helper.
package microwave_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ENTRY = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [3:0] BCD_ZERO = 4'd0;
    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] MAX_TENS = 4'd5;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= BCD_NINE;
    endfunction

endpackage

// File: rtl/bcd_entry_shift.sv
// bcd_entry_shift
// Three-digit BCD entry buffer. Digits enter at the ones position and move
// toward minutes. Once DIGITS digits are held, further shifts are dropped.
// clear empties the buffer; clear together with shift starts a fresh entry
// holding only the new key.
//   clk, clrn      clock, async active-low reset
//   shift, key     shift key into the ones position
//   clear          empty the buffer
//   ones/tens/mins current entry digits
//   full           DIGITS digits captured
//   all_zero       every entry digit is zero
module bcd_entry_shift
    import microwave_pkg::BCD_ZERO;
#(
    parameter int DIGITS = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       shift,
    input  logic       clear,
    input  logic [3:0] key,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] mins,
    output logic       full,
    output logic       all_zero
);

    localparam logic [1:0] CNT_MAX = 2'(DIGITS);

    logic [1:0] count;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ones  <= BCD_ZERO;
            tens  <= BCD_ZERO;
            mins  <= BCD_ZERO;
            count <= 2'd0;
        end else if (clear) begin
            mins <= BCD_ZERO;
            tens <= BCD_ZERO;
            if (shift) begin
                ones  <= key;
                count <= 2'd1;
            end else begin
                ones  <= BCD_ZERO;
                count <= 2'd0;
            end
        end else if (shift && !full) begin
            mins  <= tens;
            tens  <= ones;
            ones  <= key;
            count <= count + 2'd1;
        end
    end

    assign full     = (count == CNT_MAX);
    assign all_zero = (ones == BCD_ZERO) && (tens == BCD_ZERO) && (mins == BCD_ZERO);

endmodule

// File: rtl/timer_loader.sv
// timer_loader
// Keypad front end of the microwave countdown timer. Collects M:SS digits,
// validates them on start, parallel-loads the minutes/tens/ones counter
// chain, enables counting on each tick and flags completion.
//   clk, clrn            clock, async active-low reset
//   key_valid, key_code  keypad digit strobe and BCD value
//   start, stop_clear    control strobes (stop_clear wins, then start)
//   tick                 1 Hz strobe
//   zero_all             counter chain reads 0:00
//   ones/tens/mins_data  load values (entry registers)
//   loadn, cnt_en        counter parallel-load (active low) and enable
//   running, done, err   status; err pulses for one cycle on a bad start
//
// state | meaning
// IDLE  | empty entry, waiting for first digit
// ENTRY | collecting digits, waiting for start
// LOAD  | one cycle of loadn=0, counters capture the entry
// RUN   | counting down, cnt_en follows tick
// DONE  | countdown reached 0:00, waiting for stop_clear or a new digit
module timer_loader
    import microwave_pkg::ST_IDLE;
    import microwave_pkg::ST_ENTRY;
    import microwave_pkg::ST_LOAD;
    import microwave_pkg::ST_RUN;
    import microwave_pkg::ST_DONE;
    import microwave_pkg::is_bcd;
#(
    parameter int         DIGITS   = 3,
    parameter logic [3:0] MAX_TENS = microwave_pkg::MAX_TENS
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       tick,
    input  logic       zero_all,
    output logic [3:0] ones_data,
    output logic [3:0] tens_data,
    output logic [3:0] mins_data,
    output logic       loadn,
    output logic       cnt_en,
    output logic       running,
    output logic       done,
    output logic       err
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       key_ok;
    logic       do_shift;
    logic       do_clear;
    logic       reject;
    logic       entry_full;
    logic       entry_zero;

    assign key_ok = key_valid && is_bcd(key_code);

    bcd_entry_shift #(
        .DIGITS (DIGITS)
    ) u_entry (
        .clk      (clk),
        .clrn     (clrn),
        .shift    (do_shift),
        .clear    (do_clear),
        .key      (key_code),
        .ones     (ones_data),
        .tens     (tens_data),
        .mins     (mins_data),
        .full     (entry_full),
        .all_zero (entry_zero)
    );

    always_comb begin
        state_nxt = state;
        do_shift  = 1'b0;
        do_clear  = 1'b0;
        reject    = 1'b0;
        if (stop_clear) begin
            state_nxt = ST_IDLE;
            do_clear  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_ok) begin
                        do_shift  = 1'b1;
                        state_nxt = ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    // start outranks a same-cycle key even when the start
                    // itself is ignored for an empty entry
                    if (start) begin
                        if (!entry_zero) begin
                            if (tens_data > MAX_TENS)
                                reject = 1'b1;
                            else
                                state_nxt = ST_LOAD;
                        end
                    end else if (key_ok && !entry_full) begin
                        do_shift = 1'b1;
                    end
                end
                ST_LOAD: state_nxt = ST_RUN;
                ST_RUN: begin
                    if (zero_all)
                        state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    if (key_ok) begin
                        do_clear  = 1'b1;
                        do_shift  = 1'b1;
                        state_nxt = ST_ENTRY;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= ST_IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= reject;
        end
    end

    // stop_clear suppresses both strobes in the same cycle so an abort never
    // loads or advances the counters
    assign loadn   = !((state == ST_LOAD) && !stop_clear);
    assign cnt_en  = (state == ST_RUN) && tick && !zero_all && !stop_clear;
    assign running = (state == ST_LOAD) || (state == ST_RUN);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_timer_loader.sv
module tb_timer_loader;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       start = 1'b0;
    logic       stop_clear = 1'b0;
    logic       tick = 1'b0;
    logic       zero_all = 1'b0;
    logic [3:0] ones_data, tens_data, mins_data;
    logic       loadn, cnt_en, running, done, err;

    timer_loader dut (
        .clk        (clk),
        .clrn       (clrn),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .start      (start),
        .stop_clear (stop_clear),
        .tick       (tick),
        .zero_all   (zero_all),
        .ones_data  (ones_data),
        .tens_data  (tens_data),
        .mins_data  (mins_data),
        .loadn      (loadn),
        .cnt_en     (cnt_en),
        .running    (running),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_ENTRY, M_LOAD, M_RUN, M_DONE} mstate_t;

    typedef struct {
        int ones, tens, mins;
        int loadn, cnt_en, running, done, err;
    } exp_t;

    exp_t    sb[$];
    exp_t    e;
    mstate_t mst = M_IDLE;
    int      ent[$];
    int      merr = 0;
    int      n_total = 0;
    int      n_pass = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    endtask

    function automatic int dig(input int back);
        if (ent.size() > back) return ent[ent.size() - 1 - back];
        return 0;
    endfunction

    function automatic bit entry_is_zero();
        foreach (ent[i]) if (ent[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // one cycle: drive inputs, queue expected outputs, advance the model
    task automatic step(input bit sc, input bit st, input bit kv,
                        input int kc, input bit tk, input bit za);
        exp_t x;
        bit   kok;
        int   err_n;
        @(posedge clk);
        #1;
        stop_clear = sc; start = st; key_valid = kv;
        key_code = 4'(kc); tick = tk; zero_all = za;

        x.ones    = dig(0);
        x.tens    = dig(1);
        x.mins    = dig(2);
        x.loadn   = (mst == M_LOAD && !sc) ? 0 : 1;
        x.cnt_en  = (mst == M_RUN && tk && !za && !sc) ? 1 : 0;
        x.running = (mst == M_LOAD || mst == M_RUN) ? 1 : 0;
        x.done    = (mst == M_DONE) ? 1 : 0;
        x.err     = merr;
        sb.push_back(x);

        kok   = kv && (kc <= 9);
        err_n = 0;
        if (sc) begin
            mst = M_IDLE;
            ent.delete();
        end else begin
            case (mst)
                M_IDLE: if (kok) begin ent.push_back(kc); mst = M_ENTRY; end
                M_ENTRY: begin
                    if (st) begin
                        if (!entry_is_zero()) begin
                            if (dig(1) > 5) err_n = 1;
                            else mst = M_LOAD;
                        end
                    end else if (kok && ent.size() < 3) begin
                        ent.push_back(kc);
                    end
                end
                M_LOAD: mst = M_RUN;
                M_RUN: if (za) mst = M_DONE;
                M_DONE: if (kok) begin ent.delete(); ent.push_back(kc); mst = M_ENTRY; end
                default: mst = M_IDLE;
            endcase
        end
        merr = err_n;
    endtask

    task automatic key(input int k);
        step(0, 0, 1, k, 0, 0);
    endtask

    task automatic idle(input int n, input bit tk);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, tk & i[0], 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ones"}, int'(ones_data), 0);
        chk({tag, "_tens"}, int'(tens_data), 0);
        chk({tag, "_mins"}, int'(mins_data), 0);
        chk({tag, "_loadn"}, int'(loadn), 1);
        chk({tag, "_cnt_en"}, int'(cnt_en), 0);
        chk({tag, "_running"}, int'(running), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    always @(negedge clk) begin
        if (clrn && sb.size() > 0) begin
            e = sb.pop_front();
            chk("ones_data", int'(ones_data), e.ones);
            chk("tens_data", int'(tens_data), e.tens);
            chk("mins_data", int'(mins_data), e.mins);
            chk("loadn", int'(loadn), e.loadn);
            chk("cnt_en", int'(cnt_en), e.cnt_en);
            chk("running", int'(running), e.running);
            chk("done", int'(done), e.done);
            chk("err", int'(err), e.err);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk_reset_outputs("reset");
        #20;
        clrn = 1'b1;

        // 1:30 load and run, finish on a tick cycle, restart entry from DONE
        key(1); key(3); key(0);
        step(0, 1, 0, 0, 0, 0);
        idle(6, 1);
        step(0, 0, 0, 0, 1, 1);
        idle(3, 0);
        key(5);
        step(1, 0, 0, 0, 0, 0);

        // tens digit 7 rejected, entry kept
        key(0); key(7); key(5);
        step(0, 1, 0, 0, 0, 0);
        idle(3, 0);
        step(1, 0, 0, 0, 0, 0);

        // fourth digit ignored, start with empty entry ignored
        key(4); key(2); key(1); key(9);
        idle(1, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        key(0);
        step(0, 1, 0, 0, 0, 0);
        key(12);
        idle(1, 0);

        // start with stop_clear in ENTRY, stop mid-RUN on a tick
        step(1, 0, 0, 0, 0, 0);
        key(2); key(3);
        step(1, 1, 0, 0, 0, 0);
        key(2); key(3);
        step(0, 1, 0, 0, 0, 0);
        idle(4, 1);
        step(1, 0, 0, 0, 1, 0);
        idle(2, 0);

        // async reset between edges during RUN
        key(2); key(0);
        step(0, 1, 0, 0, 0, 0);
        idle(3, 1);
        @(negedge clk);
        #1;
        tick = 1'b1;
        clrn = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        @(posedge clk);
        #2;
        tick = 1'b0;
        clrn = 1'b1;
        mst = M_IDLE;
        ent.delete();
        merr = 0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 12,
                 $urandom_range(0, 99) < 30, int'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6);
        end
        step(0, 0, 0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/timer_loader.md
Name: timer_loader

Overview:
- Front end of the microwave countdown timer: captures keypad digits into a 3-digit BCD entry buffer (M:SS), validates on start, then drives the parallel-load and enable inputs of the minutes/tens/ones down-counter chain.
- Supervises the countdown and flags completion.
- Acts as the writer side of the counter load interface: data, active-low load strobe, enable, and observation of the all-zero flag.

Parameters:
- DIGITS, 3, number of BCD entry digits (ones, tens-of-seconds, minutes); fixed at 3 in this revision.
- MAX_TENS, 5, largest legal tens-of-seconds digit.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- clrn  input  1  asynchronous active-low reset.
- key_valid  input  1  one-cycle strobe: key_code holds a new digit.
- key_code  input  4  BCD digit 0-9; codes 10-15 ignored.
- start  input  1  one-cycle start strobe.
- stop_clear  input  1  one-cycle stop/clear strobe.
- tick  input  1  one-cycle 1 Hz strobe.
- zero_all  input  1  high when all three counters read 0.
- ones_data  output  4  load value for the ones counter.
- tens_data  output  4  load value for the tens counter.
- mins_data  output  4  load value for the minutes counter.
- loadn  output  1  active-low parallel-load strobe to the counters.
- cnt_en  output  1  count enable to the ones counter.
- running  output  1  high in LOAD and RUN.
- done  output  1  high in DONE.
- err  output  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (clrn low, asynchronous): state IDLE; entry digits 0; loadn=1; cnt_en=0; running=0; done=0; err=0.
- States: IDLE, ENTRY, LOAD, RUN, DONE.
- Same-cycle input priority: stop_clear > start > key_valid.
- IDLE, on key_valid with digit 0-9:
  - Shift in: mins<=tens, tens<=ones, ones<=key.
  - Go to ENTRY.
- ENTRY, digit capture:
  - On key_valid with digit 0-9, shift as in IDLE.
  - Once 3 digits have been entered, further digits are ignored.
  - Digit count saturates at 3.
  - key_code 10-15 is ignored in every state.
- ENTRY, start:
  - Entry all zero: start ignored.
  - tens > MAX_TENS: err=1 for exactly one cycle; stay in ENTRY; entry unchanged.
  - Otherwise: go to LOAD.
- LOAD (exactly 1 cycle):
  - loadn=0 and cnt_en=0, so the counters capture the entry on the closing edge.
  - Next state RUN.
- RUN:
  - cnt_en = tick, combinational from registered state, so it is high only in tick cycles.
  - loadn=1.
  - zero_all=1 sampled in RUN moves the FSM to DONE; cnt_en is forced 0 in that cycle even if tick=1.
- DONE:
  - done=1 and cnt_en=0.
  - Held until stop_clear or key_valid.
  - key_valid clears the entry, shifts in the new digit and goes to ENTRY.
- stop_clear, any state: go to IDLE, entry cleared to 0, cnt_en=0, loadn=1. This aborts a countdown in progress; the counters keep their value but stop.
- start is ignored in IDLE, LOAD, RUN and DONE.
- tick is ignored outside RUN.
- Output data:
  - ones_data, tens_data and mins_data are the entry registers, driven continuously.
  - They are stable through LOAD.
  - They are not modified in RUN, because key_valid is ignored in RUN.
- Async reset mid-RUN: outputs return to their reset values immediately; the counters receive no load.

Decomposition:
- Shared package microwave_pkg:
  - State encoding constants (3-bit: IDLE=0, ENTRY=1, LOAD=2, RUN=3, DONE=4).
  - BCD constants BCD_ZERO, BCD_NINE, MAX_TENS.
- Sub-module bcd_entry_shift:
  - 3x4-bit shift register with shift and clear inputs, digit-count saturation and an all-zero flag.
  - FSM and output logic stay in timer_loader.

Test Plan:
- Keys 1,3,0 then start → digits mins=1, tens=3, ones=0; next cycle loadn=0 with cnt_en=0 for exactly 1 cycle; then running=1, and cnt_en pulses coincide with tick.
- Keys 0,7,5 then start → err=1 for one cycle; state stays ENTRY; loadn stays 1; entry still 0/7/5.
- Keys 4,2,1,9 → fourth key ignored; data = 4/2/1; start alone with an empty entry is ignored (no loadn).
- RUN with zero_all raised on a tick cycle → cnt_en=0 that cycle, done=1 next cycle and held; key 5 → done=0, ones_data=5, state ENTRY.
- start and stop_clear in the same cycle in ENTRY → IDLE, all data 0, no loadn; stop_clear mid-RUN → cnt_en=0, running=0.
- clrn pulsed low asynchronously between edges during RUN → all outputs return to reset values before the next edge.
